gate_request_scheduler: RTL and testbench
=========================================

Name: gate_request_scheduler

Overview:
- Front-end controller that sequences the parking datapath, which accepts one `car_enter`/`car_exit` command per cycle with a one-hot `car_sel`.
- Captures requests from the entry gate panel and the exit gate panel, and arbitrates between them round-robin.
- Validates each request against live slot occupancy, then issues a single-cycle command to the datapath.
- Drives the entry and exit barrier-open timers.

Parameters:
- GATE_OPEN_CYCLES, 8, cycles a barrier stays open after an accepted command (≥1).
- GCW, 4, width of each barrier countdown counter; must hold GATE_OPEN_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- enter_req  input  1  entry panel request strobe
- enter_sel  input  3  entry slot, one-hot
- exit_req  input  1  exit panel request strobe
- exit_sel  input  3  exit slot, one-hot
- occupancy  input  3  {car3_state, car2_state, car1_state} from datapath
- car_enter  output  1  one-cycle enter command to datapath
- car_exit  output  1  one-cycle exit command to datapath
- car_sel  output  3  one-hot slot for current command, else 0
- enter_ack  output  1  pulse: entry request accepted
- enter_reject  output  1  pulse: entry request refused
- exit_ack  output  1  pulse: exit request accepted
- exit_reject  output  1  pulse: exit request refused
- gate_in_open  output  1  entry barrier open
- gate_out_open  output  1  exit barrier open
- busy  output  1  FSM not IDLE or any request pending

Behaviour:
- Reset (reset==0 at an edge):
  - All outputs 0 and pending registers cleared.
  - FSM goes to IDLE; both counters 0; last_served=EXIT, so ENTER wins first.
  - Reset mid-command aborts the command with no ack.
- Capture:
  - At an edge, if a pending register was empty before the edge and its req=1, the pending register latches the sel.
  - A req while that direction is already pending is ignored; the requester watches ack/reject.
- FSM: IDLE -> ISSUE -> SETTLE -> IDLE. All outputs are registered.
- IDLE, with at least one pending request:
  - Selection: a single pending direction is chosen. If both are pending, the direction not equal to last_served is chosen.
  - Validation for ENTER: sel is exactly one-hot AND that occupancy bit is 0. Validation for EXIT: sel is exactly one-hot AND that occupancy bit is 1.
  - Valid request:
    - Next cycle asserts car_enter or car_exit, car_sel=sel, and the matching ack, all for exactly 1 cycle.
    - Loads that gate's counter with GATE_OPEN_CYCLES.
    - Updates last_served, clears that pending register, and moves to ISSUE.
  - Invalid request (not one-hot, slot occupied, lot full, slot empty): matching reject pulses 1 cycle, pending cleared, FSM stays IDLE, last_served unchanged.
  - The other direction's pending request stays queued.
- ISSUE: commands deassert and car_sel=0; the FSM moves to SETTLE unconditionally.
- SETTLE: one dead cycle so occupancy reflects the datapath update, then IDLE.
- Latency: req at edge k -> command and ack visible after edge k+1. Sustained throughput is one command per 3 cycles.
- Barrier timers:
  - gate_x_open = (counter != 0); each counter decrements by 1 per cycle down to 0.
  - A new accepted command reloads the counter; no wrap below 0.
  - The two directions are independent of each other and of the FSM.
- Decisions use occupancy sampled in IDLE only; occupancy changes during ISSUE/SETTLE are ignored.
- Never: car_enter and car_exit high together; a command with car_sel==0; more than one ack/reject per direction per request.

Decomposition:
- Shared package `parking_pkg` holds:
  - Constants SLOT1=3'b001, SLOT2=3'b010, SLOT3=3'b100.
  - FSM state encoding (IDLE, ISSUE, SETTLE).
  - Direction enum (DIR_ENTER, DIR_EXIT).
  - A one-hot-check function.
- One sub-module, `gate_timer`: loadable down-counter with an open flag. Instantiated twice; parameter GATE_OPEN_CYCLES; ports load, open.

Test Plan:
- Enter slot 001 with occupancy 000: enter_req pulse at edge 1 -> car_enter=1, car_sel=001, enter_ack=1 for one cycle after edge 2; gate_in_open high for 8 cycles.
- Both enter(010) and exit(001) pending on the same edge, occupancy 001 -> ENTER issued first, then EXIT exactly 3 cycles later; last_served=EXIT.
- Enter 001 with occupancy 001 -> enter_reject pulse after edge 2; no car_enter; FSM stays IDLE. Repeat with occupancy 111 and sel 010 -> reject.
- Exit sel 011 (not one-hot) -> exit_reject; exit sel 100 with occupancy 000 -> exit_reject.
- Second enter_req while enter pending -> ignored; exactly one ack. Enter re-accepted 3 cycles into an open gate -> gate_in_open stays high 8 cycles from the reload.
- reset=0 during ISSUE -> next cycle all outputs 0, pending empty, gates closed; after release, the first dual request goes to ENTER.

Source files
------------

// File: rtl/gate_request_scheduler_pkg.sv
// Shared types and helpers for the parking gate front-end.
package parking_pkg;

  localparam logic [2:0] SLOT1 = 3'b001;
  localparam logic [2:0] SLOT2 = 3'b010;
  localparam logic [2:0] SLOT3 = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StSettle
  } state_e;

  typedef enum logic {
    DirEnter,
    DirExit
  } dir_e;

  // True when exactly one slot is selected.
  function automatic logic is_one_hot(logic [2:0] sel);
    return (sel == SLOT1) || (sel == SLOT2) || (sel == SLOT3);
  endfunction

endpackage

// File: rtl/gate_request_scheduler_if.sv
// Gate panel requests in, datapath commands and barrier status out.
interface gate_request_scheduler_if;

  logic       enter_req;
  logic [2:0] enter_sel;
  logic       exit_req;
  logic [2:0] exit_sel;
  logic [2:0] occupancy;
  logic       car_enter;
  logic       car_exit;
  logic [2:0] car_sel;
  logic       enter_ack;
  logic       enter_reject;
  logic       exit_ack;
  logic       exit_reject;
  logic       gate_in_open;
  logic       gate_out_open;
  logic       busy;

  // Panels plus datapath status side.
  modport master (
    output enter_req, enter_sel, exit_req, exit_sel, occupancy,
    input  car_enter, car_exit, car_sel, enter_ack, enter_reject,
    input  exit_ack, exit_reject, gate_in_open, gate_out_open, busy
  );

  // Scheduler side.
  modport slave (
    input  enter_req, enter_sel, exit_req, exit_sel, occupancy,
    output car_enter, car_exit, car_sel, enter_ack, enter_reject,
    output exit_ack, exit_reject, gate_in_open, gate_out_open, busy
  );

endinterface

// File: rtl/gate_request_scheduler_gate_timer.sv
// Loadable barrier down-counter; open while the count is non-zero.
module gate_timer #(
  parameter int unsigned GATE_OPEN_CYCLES = 8,
  parameter int unsigned GCW              = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic open
);

  localparam logic [GCW-1:0] LoadVal = GCW'(GATE_OPEN_CYCLES);

  logic [GCW-1:0] count_q, count_d;

  // Reload on an accepted command, otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LoadVal;
    end else if (count_q != '0) begin
      count_d = count_q - GCW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign open = (count_q != '0);

endmodule

// File: rtl/gate_request_scheduler.sv
// Captures entry/exit panel requests, arbitrates round-robin, validates them
// against slot occupancy and issues one-cycle commands to the datapath.
module gate_request_scheduler
  import parking_pkg::*;
#(
  parameter int unsigned GATE_OPEN_CYCLES = 8,
  parameter int unsigned GCW              = 4
) (
  input logic                     clk,
  input logic                     reset,
  gate_request_scheduler_if.slave bus
);

  state_e     state_q, state_d;
  dir_e       last_q, last_d;
  logic       enter_pend_q, enter_pend_d;
  logic [2:0] enter_psel_q, enter_psel_d;
  logic       exit_pend_q, exit_pend_d;
  logic [2:0] exit_psel_q, exit_psel_d;

  logic       car_enter_q, car_enter_d;
  logic       car_exit_q, car_exit_d;
  logic [2:0] car_sel_q, car_sel_d;
  logic       enter_ack_q, enter_ack_d;
  logic       enter_rej_q, enter_rej_d;
  logic       exit_ack_q, exit_ack_d;
  logic       exit_rej_q, exit_rej_d;

  dir_e       pick;
  logic [2:0] pick_sel;
  logic       occ_hit;
  logic       pick_ok;
  logic       load_in, load_out;

  // Arbitration, validation, command generation and request capture.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    enter_pend_d = enter_pend_q;
    enter_psel_d = enter_psel_q;
    exit_pend_d  = exit_pend_q;
    exit_psel_d  = exit_psel_q;
    car_enter_d  = 1'b0;
    car_exit_d   = 1'b0;
    car_sel_d    = 3'b000;
    enter_ack_d  = 1'b0;
    enter_rej_d  = 1'b0;
    exit_ack_d   = 1'b0;
    exit_rej_d   = 1'b0;
    load_in      = 1'b0;
    load_out     = 1'b0;
    pick         = DirEnter;
    pick_sel     = 3'b000;
    occ_hit      = 1'b0;
    pick_ok      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enter_pend_q || exit_pend_q) begin
          if (enter_pend_q && exit_pend_q) begin
            pick = (last_q == DirExit) ? DirEnter : DirExit;
          end else begin
            pick = enter_pend_q ? DirEnter : DirExit;
          end
          pick_sel = (pick == DirEnter) ? enter_psel_q : exit_psel_q;
          occ_hit  = |(pick_sel & bus.occupancy);
          // Entry needs a free slot, exit needs an occupied one.
          pick_ok  = is_one_hot(pick_sel) && ((pick == DirEnter) ? !occ_hit : occ_hit);

          if (pick == DirEnter) begin
            enter_pend_d = 1'b0;
            car_enter_d  = pick_ok;
            enter_ack_d  = pick_ok;
            enter_rej_d  = !pick_ok;
            load_in      = pick_ok;
          end else begin
            exit_pend_d = 1'b0;
            car_exit_d  = pick_ok;
            exit_ack_d  = pick_ok;
            exit_rej_d  = !pick_ok;
            load_out    = pick_ok;
          end

          if (pick_ok) begin
            car_sel_d = pick_sel;
            last_d    = pick;
            state_d   = StIssue;
          end
        end
      end
      StIssue:  state_d = StSettle;
      // Dead cycle so occupancy reflects the datapath update.
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // A direction only captures when its slot was empty before this edge.
    if (!enter_pend_q && bus.enter_req) begin
      enter_pend_d = 1'b1;
      enter_psel_d = bus.enter_sel;
    end
    if (!exit_pend_q && bus.exit_req) begin
      exit_pend_d = 1'b1;
      exit_psel_d = bus.exit_sel;
    end
  end

  // State, pending and output registers; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_q       <= DirExit;
      enter_pend_q <= 1'b0;
      enter_psel_q <= 3'b000;
      exit_pend_q  <= 1'b0;
      exit_psel_q  <= 3'b000;
      car_enter_q  <= 1'b0;
      car_exit_q   <= 1'b0;
      car_sel_q    <= 3'b000;
      enter_ack_q  <= 1'b0;
      enter_rej_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_rej_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      enter_pend_q <= enter_pend_d;
      enter_psel_q <= enter_psel_d;
      exit_pend_q  <= exit_pend_d;
      exit_psel_q  <= exit_psel_d;
      car_enter_q  <= car_enter_d;
      car_exit_q   <= car_exit_d;
      car_sel_q    <= car_sel_d;
      enter_ack_q  <= enter_ack_d;
      enter_rej_q  <= enter_rej_d;
      exit_ack_q   <= exit_ack_d;
      exit_rej_q   <= exit_rej_d;
    end
  end

  gate_timer #(
    .GATE_OPEN_CYCLES(GATE_OPEN_CYCLES),
    .GCW             (GCW)
  ) u_gate_in (
    .clk  (clk),
    .reset(reset),
    .load (load_in),
    .open (bus.gate_in_open)
  );

  gate_timer #(
    .GATE_OPEN_CYCLES(GATE_OPEN_CYCLES),
    .GCW             (GCW)
  ) u_gate_out (
    .clk  (clk),
    .reset(reset),
    .load (load_out),
    .open (bus.gate_out_open)
  );

  assign bus.car_enter    = car_enter_q;
  assign bus.car_exit     = car_exit_q;
  assign bus.car_sel      = car_sel_q;
  assign bus.enter_ack    = enter_ack_q;
  assign bus.enter_reject = enter_rej_q;
  assign bus.exit_ack     = exit_ack_q;
  assign bus.exit_reject  = exit_rej_q;
  assign bus.busy         = (state_q != StIdle) || enter_pend_q || exit_pend_q;

endmodule

// File: tb/tb_gate_request_scheduler.sv
// Bench for gate_request_scheduler: directed scenarios plus randomized traffic,
// all checked against a timing-based reference model of the scheduler.
module tb_gate_request_scheduler;

  localparam int G = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gate_request_scheduler_if bus();

  gate_request_scheduler #(
    .GATE_OPEN_CYCLES(G),
    .GCW             (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending requests, the edge index at which the scheduler
  // may next decide, and the edge index at which each barrier closes.
  int         n = 0;
  logic       m_pv[2];
  logic [2:0] m_ps[2];
  int         m_last;
  int         m_ready;
  int         m_close[2];
  logic [11:0] m_out;

  function automatic logic [11:0] dut_outs();
    return {bus.car_enter, bus.car_exit, bus.car_sel, bus.enter_ack, bus.enter_reject,
            bus.exit_ack, bus.exit_reject, bus.gate_in_open, bus.gate_out_open, bus.busy};
  endfunction

  task automatic model_edge();
    logic       pvb[2];
    logic       req[2];
    logic [2:0] rs[2];
    logic [2:0] s;
    logic       hit, ok;
    logic       ce, cx, ea, er, xa, xr;
    logic [2:0] cs;
    int         d;
    ce = 0; cx = 0; ea = 0; er = 0; xa = 0; xr = 0; cs = 3'b000;
    req[0] = bus.enter_req; req[1] = bus.exit_req;
    rs[0]  = bus.enter_sel; rs[1]  = bus.exit_sel;
    if (!reset) begin
      m_pv[0] = 0; m_pv[1] = 0; m_ps[0] = 3'b000; m_ps[1] = 3'b000;
      m_last = 1; m_ready = 0; m_close[0] = 0; m_close[1] = 0;
    end else begin
      pvb = m_pv;
      if (n >= m_ready && (pvb[0] || pvb[1])) begin
        d   = (pvb[0] && pvb[1]) ? 1 - m_last : (pvb[0] ? 0 : 1);
        s   = m_ps[d];
        hit = (s & bus.occupancy) != 3'b000;
        ok  = ($countones(s) == 1) && ((d == 0) ? !hit : hit);
        m_pv[d] = 0;
        if (ok) begin
          if (d == 0) begin ce = 1; ea = 1; end
          else begin cx = 1; xa = 1; end
          cs = s;
          m_close[d] = n + G;
          m_ready = n + 3;
          m_last = d;
        end else if (d == 0) begin
          er = 1;
        end else begin
          xr = 1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!pvb[i] && req[i]) begin
          m_pv[i] = 1;
          m_ps[i] = rs[i];
        end
      end
    end
    m_out = {ce, cx, cs, ea, er, xa, xr, n < m_close[0], n < m_close[1],
             (n + 1 < m_ready) || m_pv[0] || m_pv[1]};
    n++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic er, input logic [2:0] es, input logic xr,
                       input logic [2:0] xs);
    bus.enter_req = er; bus.enter_sel = es;
    bus.exit_req  = xr; bus.exit_sel  = xs;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 3'b000, 0, 3'b000);
    bus.occupancy = 3'b000;
    tick(); tick();
    checks++;
    if (dut_outs() !== 12'b0) begin
      errors++; $display("FAIL reset_outs got=%b exp=%b", dut_outs(), 12'b0);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dut_outs() !== m_out) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", dut_outs(), m_out);
    end
  endtask

  task automatic test_enter_basic();
    int hi;
    bus.occupancy = 3'b000;
    drive(1, 3'b001, 0, 3'b000);
    tick();
    drive(0, 3'b000, 0, 3'b000);
    tick();
    checks++;
    if ({bus.car_enter, bus.car_exit, bus.car_sel, bus.enter_ack} !== 6'b1_0_001_1) begin
      errors++;
      $display("FAIL enter_basic_cmd got=%b exp=%b",
               {bus.car_enter, bus.car_exit, bus.car_sel, bus.enter_ack}, 6'b1_0_001_1);
    end
    hi = int'(bus.gate_in_open);
    for (int i = 0; i < 12; i++) begin
      tick();
      hi += int'(bus.gate_in_open);
      checks++;
      if (dut_outs() !== m_out) begin
        errors++; $display("FAIL enter_basic_model cyc=%0d got=%b exp=%b", n, dut_outs(), m_out);
      end
    end
    checks++;
    if (hi !== G) begin
      errors++; $display("FAIL enter_basic_gate_len got=%0d exp=%0d", hi, G);
    end
  endtask

  task automatic test_dual();
    logic [4:0] exp_cmd;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    bus.occupancy = 3'b001;
    drive(1, 3'b010, 1, 3'b001);
    tick();
    drive(0, 3'b000, 0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_cmd = (i == 0) ? 5'b1_0_010 : (i == 3) ? 5'b0_1_001 : 5'b0_0_000;
      checks++;
      if ({bus.car_enter, bus.car_exit, bus.car_sel} !== exp_cmd) begin
        errors++;
        $display("FAIL dual_order step=%0d got=%b exp=%b", i,
                 {bus.car_enter, bus.car_exit, bus.car_sel}, exp_cmd);
      end
      checks++;
      if (dut_outs() !== m_out) begin
        errors++; $display("FAIL dual_model cyc=%0d got=%b exp=%b", n, dut_outs(), m_out);
      end
    end
  endtask

  task automatic test_reject();
    logic [2:0] occ_tab[2];
    logic [2:0] sel_tab[2];
    occ_tab[0] = 3'b001; sel_tab[0] = 3'b001;
    occ_tab[1] = 3'b111; sel_tab[1] = 3'b010;
    for (int k = 0; k < 2; k++) begin
      bus.occupancy = occ_tab[k];
      drive(1, sel_tab[k], 0, 3'b000);
      tick();
      drive(0, 3'b000, 0, 3'b000);
      tick();
      checks++;
      if ({bus.car_enter, bus.enter_ack, bus.enter_reject, bus.busy} !== 4'b0010) begin
        errors++;
        $display("FAIL enter_reject%0d got=%b exp=%b", k,
                 {bus.car_enter, bus.enter_ack, bus.enter_reject, bus.busy}, 4'b0010);
      end
      tick();
      checks++;
      if (dut_outs() !== m_out) begin
        errors++; $display("FAIL enter_reject_model cyc=%0d got=%b exp=%b", n, dut_outs(), m_out);
      end
    end
  endtask

  task automatic test_exit_reject();
    logic [2:0] occ_tab[2];
    logic [2:0] sel_tab[2];
    occ_tab[0] = 3'b111; sel_tab[0] = 3'b011;
    occ_tab[1] = 3'b000; sel_tab[1] = 3'b100;
    for (int k = 0; k < 2; k++) begin
      bus.occupancy = occ_tab[k];
      drive(0, 3'b000, 1, sel_tab[k]);
      tick();
      drive(0, 3'b000, 0, 3'b000);
      tick();
      checks++;
      if ({bus.car_exit, bus.exit_ack, bus.exit_reject} !== 3'b001) begin
        errors++;
        $display("FAIL exit_reject%0d got=%b exp=%b", k,
                 {bus.car_exit, bus.exit_ack, bus.exit_reject}, 3'b001);
      end
      tick();
    end
  endtask

  task automatic test_ignore_reload();
    int acks, hi;
    bus.occupancy = 3'b000;
    for (int i = 0; i < 10; i++) tick();
    // Request held for two edges: the second edge sees it pending and ignores it.
    drive(1, 3'b010, 0, 3'b000);
    tick(); tick();
    drive(0, 3'b000, 0, 3'b000);
    acks = int'(bus.enter_ack);
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(bus.enter_ack);
    end
    checks++;
    if (acks !== 1) begin
      errors++; $display("FAIL ignore_second_req acks got=%0d exp=1", acks);
    end
    for (int i = 0; i < 10; i++) tick();
    drive(1, 3'b001, 0, 3'b000); tick();
    drive(0, 3'b000, 0, 3'b000); tick();
    tick();
    drive(1, 3'b100, 0, 3'b000); tick();
    drive(0, 3'b000, 0, 3'b000); tick();
    checks++;
    if ({bus.enter_ack, bus.car_sel, bus.gate_in_open} !== 5'b1_100_1) begin
      errors++;
      $display("FAIL reload_ack got=%b exp=%b",
               {bus.enter_ack, bus.car_sel, bus.gate_in_open}, 5'b1_100_1);
    end
    hi = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      hi += int'(bus.gate_in_open);
      checks++;
      if (dut_outs() !== m_out) begin
        errors++; $display("FAIL reload_model cyc=%0d got=%b exp=%b", n, dut_outs(), m_out);
      end
    end
    checks++;
    if (hi !== G) begin
      errors++; $display("FAIL reload_gate_len got=%0d exp=%0d", hi, G);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0; tick(); reset = 1'b1; tick();
    bus.occupancy = 3'b001;
    drive(1, 3'b010, 1, 3'b001); tick();
    drive(0, 3'b000, 0, 3'b000); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (dut_outs() !== 12'b0) begin
      errors++; $display("FAIL reset_mid_outs got=%b exp=%b", dut_outs(), 12'b0);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (dut_outs() !== 12'b0) begin
      errors++; $display("FAIL reset_mid_idle got=%b exp=%b", dut_outs(), 12'b0);
    end
    drive(1, 3'b010, 1, 3'b001); tick();
    drive(0, 3'b000, 0, 3'b000); tick();
    checks++;
    if ({bus.car_enter, bus.car_exit, bus.car_sel} !== 5'b1_0_010) begin
      errors++;
      $display("FAIL reset_mid_first_enter got=%b exp=%b",
               {bus.car_enter, bus.car_exit, bus.car_sel}, 5'b1_0_010);
    end
  endtask

  task automatic test_random();
    int hold;
    logic [2:0] s;
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold == 0) begin
        bus.occupancy = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 8);
      end
      hold--;
      s = ($urandom_range(0, 9) < 7) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      bus.enter_sel = s;
      bus.enter_req = ($urandom_range(0, 9) < 3);
      s = ($urandom_range(0, 9) < 7) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      bus.exit_sel = s;
      bus.exit_req = ($urandom_range(0, 9) < 3);
      reset = ($urandom_range(0, 99) != 0);
      tick();
      checks++;
      if (dut_outs() !== m_out) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", n, dut_outs(), m_out);
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_enter_basic();
    test_dual();
    test_reject();
    test_exit_reject();
    test_ignore_reload();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
